platform_spawner: RTL

Keeps the pool of up to NUM_PLAT active platforms for the NS-Shaft playfield and sits directly downstream of the 9-bit random-x LFSR. Once per accepted frame tick it scrolls every live platform up, retires platforms that reach the ceiling, and spawns a new platform at the bottom row when the spawn timer allows. To spawn, it pulses the LFSR enable and takes the next random value as the platform's x position. The renderer and collision logic read platform slots through a registered read port.

---
 rtl/platform_spawner.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/platform_spawner.sv
// ---------------------------------------------------------------------------
// platform_spawner
//
// Keeps the pool of NS-Shaft platforms. On every accepted frame tick the
// block scrolls each live platform up one slot per cycle, retires the ones
// that reach the ceiling, then (timer permitting) pulses the LFSR enable and
// spawns a new platform on the bottom row at the next random x.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   clear        synchronous new-game clear (slots, timer, overrun, FSM)
//   frame_tick   one-cycle pulse per video frame
//   rand_x       9-bit LFSR output, sampled one cycle after rand_en
//   rand_en      LFSR enable pulse (REQ state only)
//   rd_idx       slot to read
//   rd_x/rd_y    registered x / y of slot rd_idx (0 when rd_idx >= NUM_PLAT)
//   rd_vld       registered valid bit of slot rd_idx
//   plat_valid   live valid vector of all slots
//   busy         high whenever an update is in progress
//   update_done  one-cycle pulse at the end of each update
//   overrun      sticky: a frame_tick arrived while busy
// ---------------------------------------------------------------------------
module platform_spawner #(
    parameter int NUM_PLAT     = 6,
    parameter int SPAWN_FRAMES = 30,
    parameter int SCROLL       = 1,
    parameter int Y_BOTTOM     = 239,
    parameter int Y_TOP        = 16,
    parameter int X_MAX        = 288
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clear,
    input  logic                frame_tick,
    input  logic [8:0]          rand_x,
    output logic                rand_en,
    input  logic [2:0]          rd_idx,
    output logic [8:0]          rd_x,
    output logic [7:0]          rd_y,
    output logic                rd_vld,
    output logic [NUM_PLAT-1:0] plat_valid,
    output logic                busy,
    output logic                update_done,
    output logic                overrun
);

    localparam int TW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

    localparam logic [7:0]    Y_LIMIT   = 8'(Y_TOP + SCROLL);
    localparam logic [7:0]    SCROLL_V  = 8'(SCROLL);
    localparam logic [7:0]    Y_SPAWN   = 8'(Y_BOTTOM);
    localparam logic [8:0]    X_LIMIT   = 9'(X_MAX);
    localparam logic [2:0]    LAST_IDX  = 3'(NUM_PLAT - 1);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(SPAWN_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCROLL,
        ST_CHECK,
        ST_REQ,
        ST_WR,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [NUM_PLAT-1:0] slot_v;
    logic [8:0]          slot_x [NUM_PLAT];
    logic [7:0]          slot_y [NUM_PLAT];
    logic [2:0]          idx_q;
    logic [TW-1:0]       timer_q;

    logic                free_any;
    logic [2:0]          free_idx;

    // Platforms are 32 px wide, so the left edge saturates at X_MAX.
    function automatic logic [8:0] clamp_x(input logic [8:0] x);
        return (x > X_LIMIT) ? X_LIMIT : x;
    endfunction

    // Lowest-index free slot; scanning downward lets the lowest index win.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            if (!slot_v[i]) begin
                free_any = 1'b1;
                free_idx = 3'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rand_en     = 1'b0;
        update_done = 1'b0;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:   if (frame_tick) state_d = ST_SCROLL;
            ST_SCROLL: if (idx_q == LAST_IDX) state_d = ST_CHECK;
            ST_CHECK: begin
                if (timer_q != '0)  state_d = ST_DONE;
                else if (free_any)  state_d = ST_REQ;
                else                state_d = ST_DONE;
            end
            ST_REQ: begin
                rand_en = 1'b1;
                state_d = ST_WR;
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: begin
                update_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    // -----------------------------------------------------------------------
    // Slot pool, scroll index, spawn timer and overrun flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_v  <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
        end else if (clear) begin
            slot_v  <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            overrun <= 1'b0;
        end else begin
            if (frame_tick && state_q != ST_IDLE) overrun <= 1'b1;
            case (state_q)
                ST_IDLE: idx_q <= '0;
                ST_SCROLL: begin
                    if (slot_v[idx_q]) begin
                        if (slot_y[idx_q] < Y_LIMIT)
                            slot_v[idx_q] <= 1'b0;
                        else
                            slot_y[idx_q] <= slot_y[idx_q] - SCROLL_V;
                    end
                    idx_q <= idx_q + 3'd1;
                end
                ST_CHECK: begin
                    if (timer_q != '0) timer_q <= timer_q - TW'(1);
                end
                ST_WR: begin
                    // rand_x has advanced by now: rand_en was pulsed last cycle.
                    slot_v[free_idx] <= 1'b1;
                    slot_x[free_idx] <= clamp_x(rand_x);
                    slot_y[free_idx] <= Y_SPAWN;
                    timer_q          <= TMR_RELOAD;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registered read port (sees slot contents from before any same-cycle write)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_x   <= '0;
            rd_y   <= '0;
            rd_vld <= 1'b0;
        end else if (int'(rd_idx) < NUM_PLAT) begin
            rd_x   <= slot_x[rd_idx];
            rd_y   <= slot_y[rd_idx];
            rd_vld <= slot_v[rd_idx];
        end else begin
            rd_x   <= '0;
            rd_y   <= '0;
            rd_vld <= 1'b0;
        end
    end

    assign plat_valid = slot_v;

endmodule
